// File: rtl/fb_pkg.sv
// Frame-buffer geometry, pixel format and arbiter state type shared by the
// VGA draw path, the game painters and the write arbiter.
package fb_pkg;

    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 3;

    // Pixel colours, packed as {B,G,R}
    localparam logic [DATA_W-1:0] COL_BLACK   = 3'b000;
    localparam logic [DATA_W-1:0] COL_RED     = 3'b001;
    localparam logic [DATA_W-1:0] COL_GREEN   = 3'b010;
    localparam logic [DATA_W-1:0] COL_YELLOW  = 3'b011;
    localparam logic [DATA_W-1:0] COL_BLUE    = 3'b100;
    localparam logic [DATA_W-1:0] COL_MAGENTA = 3'b101;
    localparam logic [DATA_W-1:0] COL_CYAN    = 3'b110;
    localparam logic [DATA_W-1:0] COL_WHITE   = 3'b111;

    typedef enum logic {IDLE, SERVE} arb_state_t;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Bundle between the pixel painters, the write arbiter and RAM port A.
// The arbiter uses the slave view; painters and RAM sit on the master view.
interface fb_write_arbiter_if import fb_pkg::*; #(
    parameter int NUM_REQ = 3
);

    localparam int GRANT_W = $clog2(NUM_REQ);

    logic                        vblank;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [GRANT_W-1:0]          grant_id;
    logic                        busy;
    logic                        clear_err;
    logic                        addr_err;

    modport slave (
        input  vblank, req_valid, req_addr, req_data, clear_err,
        output req_ready, mem_we, mem_addr, mem_wdata, grant_id, busy, addr_err
    );

    modport master (
        output vblank, req_valid, req_addr, req_data, clear_err,
        input  req_ready, mem_we, mem_addr, mem_wdata, grant_id, busy, addr_err
    );

endinterface

// File: rtl/rr_pick.sv
// Circular priority picker: finds the first set request at or after ptr,
// wrapping past the top index back to 0.
module rr_pick import fb_pkg::*; #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               found,
    output logic [PTR_W-1:0]   idx
);

    // Pick the set request with the smallest circular distance from ptr
    always_comb begin
        int ptrI;
        int off;
        int bestOff;
        found   = 1'b0;
        idx     = '0;
        ptrI    = int'(ptr);
        off     = 0;
        bestOff = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            off = (j >= ptrI) ? (j - ptrI) : (j + NUM_REQ - ptrI);
            if (req[j] && (off < bestOff)) begin
                bestOff = off;
                idx     = PTR_W'(j);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin owner of the frame-buffer write port. Grants painters only
// during vertical blank, bounds each burst, and drops out-of-range beats
// while flagging them in a sticky error bit.
module fb_write_arbiter import fb_pkg::*; #(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    fb_write_arbiter_if.slave  bus
);

    localparam int GRANT_W = $clog2(NUM_REQ);
    localparam int CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   LAST_BEAT   = CNT_W'(MAX_BURST - 1);
    localparam logic [GRANT_W-1:0] LAST_REQ    = GRANT_W'(NUM_REQ - 1);
    localparam logic [ADDR_W:0]    DEPTH_LIMIT = (ADDR_W + 1)'(FB_DEPTH);

    arb_state_t          state, stateNext;
    logic [GRANT_W-1:0]  rrPtr, rrPtrNext;
    logic [GRANT_W-1:0]  owner, ownerNext;
    logic [CNT_W-1:0]    beatCnt, beatCntNext;
    logic                pickFound;
    logic [GRANT_W-1:0]  pickIdx;
    logic                ownerValid;
    logic [ADDR_W-1:0]   ownerAddr;
    logic [DATA_W-1:0]   ownerData;
    logic                serving;
    logic                accept;
    logic                addrOk;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (GRANT_W)
    ) picker (
        .req   (bus.req_valid),
        .ptr   (rrPtr),
        .found (pickFound),
        .idx   (pickIdx)
    );

    assign serving      = (state == SERVE);
    assign accept       = serving && bus.vblank && ownerValid;
    assign addrOk       = ({1'b0, ownerAddr} < DEPTH_LIMIT);
    assign bus.busy     = serving;
    assign bus.grant_id = owner;

    // Select the current owner's request lane from the flattened buses
    always_comb begin
        ownerValid = 1'b0;
        ownerAddr  = '0;
        ownerData  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == GRANT_W'(i)) begin
                ownerValid = bus.req_valid[i];
                ownerAddr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                ownerData  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready comes only from registered ownership and the vblank level, never from valid
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = serving && bus.vblank && (owner == GRANT_W'(i));
        end
    end

    // Next-state logic: grant on vblank, release on full burst, dropped valid or window close
    always_comb begin
        stateNext   = state;
        rrPtrNext   = rrPtr;
        ownerNext   = owner;
        beatCntNext = beatCnt;
        case (state)
            IDLE: begin
                if (bus.vblank && pickFound) begin
                    stateNext   = SERVE;
                    ownerNext   = pickIdx;
                    beatCntNext = '0;
                end
            end
            SERVE: begin
                if (accept) begin
                    beatCntNext = beatCnt + 1'b1;
                end
                if (!bus.vblank || !ownerValid || (accept && (beatCnt == LAST_BEAT))) begin
                    stateNext = IDLE;
                    rrPtrNext = (owner == LAST_REQ) ? '0 : owner + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            rrPtr   <= '0;
            owner   <= '0;
            beatCnt <= '0;
        end else begin
            state   <= stateNext;
            rrPtr   <= rrPtrNext;
            owner   <= ownerNext;
            beatCnt <= beatCntNext;
        end
    end

    // Registered RAM write port; address and data hold between writes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= accept && addrOk;
            if (accept && addrOk) begin
                bus.mem_addr  <= ownerAddr;
                bus.mem_wdata <= ownerData;
            end
        end
    end

    // Sticky out-of-range flag; a new bad beat beats a simultaneous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.addr_err <= 1'b0;
        end else if (accept && !addrOk) begin
            bus.addr_err <= 1'b1;
        end else if (bus.clear_err) begin
            bus.addr_err <= 1'b0;
        end
    end

endmodule
